// File: rtl/uart_proc_sequencer_if.sv
// Memory/bus bundle between the run sequencer, the UART memory port, the processor and both memories.
// slave = sequencer view, master = surrounding system view.
interface uart_proc_sequencer_if #(
    parameter int DW  = 12,
    parameter int AW  = 12,
    parameter int IAW = 8
);
    logic [AW-1:0]  uart_addr;
    logic           uart_wrEn;
    logic [DW-1:0]  uart_wdata;
    logic [DW-1:0]  uart_rdata;
    logic [IAW-1:0] proc_ins_addr;
    logic [DW-1:0]  proc_ins_rdata;
    logic [AW-1:0]  proc_addr;
    logic           proc_wrEn;
    logic [DW-1:0]  proc_wdata;
    logic [DW-1:0]  proc_rdata;
    logic [IAW-1:0] imem_addr;
    logic           imem_wrEn;
    logic [DW-1:0]  imem_wdata;
    logic [DW-1:0]  imem_q;
    logic [AW-1:0]  dmem_addr;
    logic           dmem_wrEn;
    logic [DW-1:0]  dmem_wdata;
    logic [DW-1:0]  dmem_q;

    modport slave (
        input  uart_addr, uart_wrEn, uart_wdata, proc_ins_addr,
               proc_addr, proc_wrEn, proc_wdata, imem_q, dmem_q,
        output uart_rdata, proc_ins_rdata, proc_rdata,
               imem_addr, imem_wrEn, imem_wdata,
               dmem_addr, dmem_wrEn, dmem_wdata
    );

    modport master (
        output uart_addr, uart_wrEn, uart_wdata, proc_ins_addr,
               proc_addr, proc_wrEn, proc_wdata, imem_q, dmem_q,
        input  uart_rdata, proc_ins_rdata, proc_rdata,
               imem_addr, imem_wrEn, imem_wdata,
               dmem_addr, dmem_wrEn, dmem_wdata
    );
endinterface

// File: rtl/uart_proc_sequencer.sv
// Run sequencer: UART imem load, UART dmem load, processor run, UART dmem dump; arbitrates both memories.
// Optional PROCESS-state watchdog enabled by defining SEQ_WATCHDOG_EN.
module uart_proc_sequencer #(
    parameter int          memWordLength    = 12,
    parameter int          memAddressLength = 12,
    parameter int          insAddressLength = 8,
    parameter logic [23:0] watchdogLimit    = 24'hFFFFFF
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic                  mem_received,
    input  logic                  mem_transmitted,
    output logic                  uart_txStart,
    output logic                  proc_start,
    input  logic                  proc_done,
    output logic [2:0]            seq_state,
    output logic                  run_done,
    output logic                  run_error,
    uart_proc_sequencer_if.slave  bus
);
    typedef enum logic [2:0] {
        IDLE       = 3'd0,
        RX_INS     = 3'd1,
        RX_DATA    = 3'd2,
        PROC_START = 3'd3,
        PROCESS    = 3'd4,
        TX_START   = 3'd5,
        TX_DATA    = 3'd6,
        DONE       = 3'd7
    } state_t;

    state_t state_q, state_d;
    logic   start_armed_q, start_armed_d;
    logic   proc_start_q, proc_start_d;
    logic   uart_txStart_q, uart_txStart_d;
    logic   run_done_q, run_done_d;
    logic   run_error_q, run_error_d;
    logic   launch;
    logic   timeout;

`ifdef SEQ_WATCHDOG_EN
    logic [23:0] wd_cnt_q, wd_cnt_d;

    // Counter sits at zero outside PROCESS, so the first PROCESS cycle sees 0.
    always_comb begin
        wd_cnt_d = '0;
        if (state_q == PROCESS) wd_cnt_d = wd_cnt_q + 24'd1;
    end

    assign timeout = (state_q == PROCESS) && (wd_cnt_q == watchdogLimit - 24'd1);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) wd_cnt_q <= '0;
        else      wd_cnt_q <= wd_cnt_d;
    end
`else
    logic unused_cfg;
    assign unused_cfg = ^watchdogLimit;
    assign timeout    = 1'b0;
`endif

    assign launch = ((state_q == IDLE) || (state_q == DONE)) && !start && start_armed_q;

    always_comb begin
        state_d       = state_q;
        start_armed_d = start ? 1'b1 : start_armed_q;
        run_error_d   = run_error_q;
        unique case (state_q)
            IDLE, DONE: if (launch) begin
                state_d       = RX_INS;
                start_armed_d = 1'b0;
                run_error_d   = 1'b0;
            end
            RX_INS:     if (mem_received) state_d = RX_DATA;
            RX_DATA:    if (mem_received) state_d = PROC_START;
            PROC_START: state_d = PROCESS;
            PROCESS: begin
                // proc_done wins over a coincident timeout
                if (proc_done) begin
                    state_d = TX_START;
                end else if (timeout) begin
                    state_d     = TX_START;
                    run_error_d = 1'b1;
                end
            end
            TX_START:   state_d = TX_DATA;
            TX_DATA:    if (mem_transmitted) state_d = DONE;
            default:    state_d = IDLE;
        endcase
        proc_start_d   = (state_d == PROC_START);
        uart_txStart_d = (state_d != TX_START);
        run_done_d     = (state_d == DONE);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q        <= IDLE;
            start_armed_q  <= 1'b0;
            proc_start_q   <= 1'b0;
            uart_txStart_q <= 1'b1;
            run_done_q     <= 1'b0;
            run_error_q    <= 1'b0;
        end else begin
            state_q        <= state_d;
            start_armed_q  <= start_armed_d;
            proc_start_q   <= proc_start_d;
            uart_txStart_q <= uart_txStart_d;
            run_done_q     <= run_done_d;
            run_error_q    <= run_error_d;
        end
    end

    assign seq_state    = state_q;
    assign proc_start   = proc_start_q;
    assign uart_txStart = uart_txStart_q;
    assign run_done     = run_done_q;
`ifdef SEQ_WATCHDOG_EN
    assign run_error    = run_error_q;
`else
    assign run_error    = 1'b0;
`endif

    // Memory port mux; UART addresses are parked on both memories when nobody owns them.
    always_comb begin
        bus.imem_addr  = bus.uart_addr[insAddressLength-1:0];
        bus.imem_wdata = bus.uart_wdata;
        bus.imem_wrEn  = 1'b0;
        bus.dmem_addr  = bus.uart_addr;
        bus.dmem_wdata = bus.uart_wdata;
        bus.dmem_wrEn  = 1'b0;
        unique case (state_q)
            RX_INS:  bus.imem_wrEn = bus.uart_wrEn;
            RX_DATA, TX_DATA: bus.dmem_wrEn = bus.uart_wrEn;
            PROCESS: begin
                bus.imem_addr  = bus.proc_ins_addr;
                bus.imem_wdata = '0;
                bus.dmem_addr  = bus.proc_addr;
                bus.dmem_wdata = bus.proc_wdata;
                bus.dmem_wrEn  = bus.proc_wrEn;
            end
            default: ;
        endcase
    end

    assign bus.uart_rdata     = bus.dmem_q;
    assign bus.proc_rdata     = bus.dmem_q;
    assign bus.proc_ins_rdata = bus.imem_q;

    logic [memWordLength-1:0]    unused_w;
    logic [memAddressLength-1:0] unused_a;
    assign unused_w = '0;
    assign unused_a = '0;
endmodule

// File: tb/tb_uart_proc_sequencer.sv
// Scoreboard bench for uart_proc_sequencer: stimulus pushes expectations, negedge monitor checks them.
module tb_uart_proc_sequencer;
    localparam int DW = 12, AW = 12, IAW = 8;
`ifdef SEQ_WATCHDOG_EN
    localparam logic [23:0] WD = 24'd100;
`else
    localparam logic [23:0] WD = 24'hFFFFFF;
`endif

    logic clk = 1'b0;
    logic rst, start, mem_received, mem_transmitted, proc_done;
    logic uart_txStart, proc_start, run_done, run_error;
    logic [2:0] seq_state;

    uart_proc_sequencer_if #(.DW(DW), .AW(AW), .IAW(IAW)) bus ();

    uart_proc_sequencer #(
        .memWordLength(DW), .memAddressLength(AW),
        .insAddressLength(IAW), .watchdogLimit(WD)
    ) dut (
        .clk(clk), .rst(rst), .start(start),
        .mem_received(mem_received), .mem_transmitted(mem_transmitted),
        .uart_txStart(uart_txStart), .proc_start(proc_start), .proc_done(proc_done),
        .seq_state(seq_state), .run_done(run_done), .run_error(run_error),
        .bus(bus.slave)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [2:0]  st;
        logic        ps, txs, rd, re, iw, dw;
        logic [11:0] daddr;
        logic [11:0] urd;
        logic [11:0] ird;
    } obs_t;

    obs_t  exp_q[$];
    string nm_q[$];
    int    n_cmp = 0, n_bad = 0;

    // Monitor: one pending expectation is compared per falling edge.
    always @(negedge clk) begin
        obs_t  e, a;
        string nm;
        if (exp_q.size() > 0) begin
            e  = exp_q.pop_front();
            nm = nm_q.pop_front();
            a  = '{seq_state, proc_start, uart_txStart, run_done, run_error,
                   bus.imem_wrEn, bus.dmem_wrEn, bus.dmem_addr, bus.uart_rdata,
                   bus.proc_ins_rdata};
            n_cmp++;
            if (a !== e) begin
                n_bad++;
                $display("FAIL %s: got st=%0d ps=%b txs=%b rd=%b re=%b iw=%b dw=%b da=%h urd=%h ird=%h, want st=%0d ps=%b txs=%b rd=%b re=%b iw=%b dw=%b da=%h urd=%h ird=%h",
                         nm, a.st, a.ps, a.txs, a.rd, a.re, a.iw, a.dw, a.daddr, a.urd, a.ird,
                         e.st, e.ps, e.txs, e.rd, e.re, e.iw, e.dw, e.daddr, e.urd, e.ird);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic ex(input logic [2:0] st, input logic ps, txs, rd, re, iw, dw, input string nm);
        obs_t e;
        e = '{st, ps, txs, rd, re, iw, dw, (st == 3'd4) ? 12'h222 : 12'h111, 12'hABC, 12'h5A5};
        exp_q.push_back(e);
        nm_q.push_back(nm);
    endtask

    // From IDLE/DONE with start armed: press start and walk to the first PROCESS cycle.
    task automatic run_to_process(input logic [2:0] from_st, input logic from_rd);
        start = 1'b0;        ex(from_st, 0, 1, from_rd, 0, 0, 0, "press");
        tick(); start = 1'b1; mem_received = 1'b1; ex(3'd1, 0, 1, 0, 0, 0, 0, "rx_ins");
        tick(); mem_received = 1'b0; ex(3'd2, 0, 1, 0, 0, 0, 0, "rx_data_a");
        tick(); mem_received = 1'b1; ex(3'd2, 0, 1, 0, 0, 0, 0, "rx_data_b");
        tick(); mem_received = 1'b0; ex(3'd3, 1, 1, 0, 0, 0, 0, "proc_start");
        tick(); ex(3'd4, 0, 1, 0, 0, 0, 0, "process_entry");
    endtask

    initial begin
        rst = 1'b0; start = 1'b0; mem_received = 1'b0; mem_transmitted = 1'b0; proc_done = 1'b0;
        bus.uart_addr = 12'h111; bus.uart_wrEn = 1'b0; bus.uart_wdata = 12'h0F0;
        bus.proc_ins_addr = 8'h33; bus.proc_addr = 12'h222; bus.proc_wrEn = 1'b0;
        bus.proc_wdata = 12'h00F; bus.imem_q = 12'h5A5; bus.dmem_q = 12'hABC;

        tick(); ex(3'd0, 0, 1, 0, 0, 0, 0, "reset");
        tick(); rst = 1'b1; ex(3'd0, 0, 1, 0, 0, 0, 0, "rst_release");
        for (int i = 0; i < 3; i++) begin
            tick(); ex(3'd0, 0, 1, 0, 0, 0, 0, "held_low_not_armed");
        end
        tick(); start = 1'b1; ex(3'd0, 0, 1, 0, 0, 0, 0, "arm");
        tick(); start = 1'b0; ex(3'd0, 0, 1, 0, 0, 0, 0, "press_seen");
        tick(); start = 1'b1; bus.uart_wrEn = 1'b1; ex(3'd1, 0, 1, 0, 0, 1, 0, "rx_ins_wr");
        tick(); bus.uart_wrEn = 1'b0; mem_transmitted = 1'b1; ex(3'd1, 0, 1, 0, 0, 0, 0, "spurious_tx");
        tick(); mem_transmitted = 1'b0; mem_received = 1'b1; ex(3'd1, 0, 1, 0, 0, 0, 0, "rx_ins_done");
        tick(); mem_received = 1'b0; bus.uart_wrEn = 1'b1; ex(3'd2, 0, 1, 0, 0, 0, 1, "rx_data_wr");
        tick(); bus.uart_wrEn = 1'b0; mem_received = 1'b1; ex(3'd2, 0, 1, 0, 0, 0, 0, "rx_data_done");
        tick(); mem_received = 1'b0; proc_done = 1'b1; ex(3'd3, 1, 1, 0, 0, 0, 0, "proc_start_pulse");
        tick(); proc_done = 1'b0; mem_received = 1'b1; bus.proc_wrEn = 1'b1;
        ex(3'd4, 0, 1, 0, 0, 0, 1, "process_wr");
        tick(); mem_received = 1'b0; bus.proc_wrEn = 1'b0; ex(3'd4, 0, 1, 0, 0, 0, 0, "spurious_rx");
        for (int i = 0; i < 47; i++) begin
            tick(); ex(3'd4, 0, 1, 0, 0, 0, 0, "process_wait");
        end
        tick(); proc_done = 1'b1; ex(3'd4, 0, 1, 0, 0, 0, 0, "proc_done_seen");
        tick(); proc_done = 1'b0; ex(3'd5, 0, 0, 0, 0, 0, 0, "tx_start_pulse");
        tick(); bus.proc_wrEn = 1'b1; ex(3'd6, 0, 1, 0, 0, 0, 0, "tx_data_proc_masked");
        tick(); bus.proc_wrEn = 1'b0; mem_transmitted = 1'b1; ex(3'd6, 0, 1, 0, 0, 0, 0, "tx_data_done");
        tick(); mem_transmitted = 1'b0; ex(3'd7, 0, 1, 1, 0, 0, 0, "done");
        tick(); ex(3'd7, 0, 1, 1, 0, 0, 0, "done_hold");

        tick(); run_to_process(3'd7, 1'b1);
        tick(); rst = 1'b0; ex(3'd0, 0, 1, 0, 0, 0, 0, "reset_mid_run");
        tick(); rst = 1'b1; ex(3'd0, 0, 1, 0, 0, 0, 0, "after_reset");

`ifdef SEQ_WATCHDOG_EN
        tick(); run_to_process(3'd0, 1'b0);
        for (int i = 1; i < 100; i++) begin
            tick(); ex(3'd4, 0, 1, 0, 0, 0, 0, "wd_process");
        end
        tick(); ex(3'd5, 0, 0, 0, 1, 0, 0, "wd_timeout");
        tick(); ex(3'd6, 0, 1, 0, 1, 0, 0, "wd_error_held");
`endif

        repeat (3) @(posedge clk);
        if (exp_q.size() != 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL drain: got %0d pending, want 0", exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
